// File: rtl/bcd_counter4_pkg.sv
// Shared BCD types and per-digit arithmetic for the four-digit counter.
package counter_pkg;

    localparam int NDIG = 4;

    typedef logic [3:0] bcd_t;
    typedef bcd_t [NDIG-1:0] bcd_vec_t;

    function automatic bcd_t bcd_step(input bcd_t d, input logic up, output logic carry);
        bcd_t r;
        r     = d;
        carry = 1'b0;
        if (up) begin
            if (d >= 4'd9) begin
                r     = 4'd0;
                carry = 1'b1;
            end else begin
                r = d + 4'd1;
            end
        end else begin
            if (d == 4'd0) begin
                r     = 4'd9;
                carry = 1'b1;
            end else begin
                r = d - 4'd1;
            end
        end
        return r;
    endfunction

    function automatic bcd_t bcd_sat(input bcd_t d);
        return (d > 4'd9) ? 4'd9 : d;
    endfunction

endpackage

// File: rtl/bcd_counter4_if.sv
// Control and display bus of the BCD counter; clock and reset stay outside.
interface bcd_counter4_if;
    logic        run;
    logic        up;
    logic        clear;
    logic        load;
    logic [15:0] load_value;
    logic [15:0] digits;
    logic        tick;
    logic        wrap;

    modport master (
        output run, up, clear, load, load_value,
        input  digits, tick, wrap
    );

    modport slave (
        input  run, up, clear, load, load_value,
        output digits, tick, wrap
    );
endinterface

// File: rtl/bcd_counter4_tick_gen.sv
// Prescaler: counts 0..DIV-1 while enabled and flags the last cycle of each period.
module tick_gen #(
    parameter int DIV = 10
) (
    input  logic clock,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic tick
);
    localparam int W = (DIV > 1) ? $clog2(DIV) : 1;

    if (DIV < 2) begin : g_bad_div
        $error("tick_gen: DIV must be at least 2");
    end

    logic [W-1:0] pre_r;
    logic         last_s;

    assign last_s = (pre_r == W'(DIV - 1));
    assign tick   = en & last_s;

    // prescaler holds while disabled, so a pause shifts the next step by its length
    always_ff @(posedge clock) begin
        if (reset) begin
            pre_r <= '0;
        end else if (clr) begin
            pre_r <= '0;
        end else if (en) begin
            if (last_s) begin
                pre_r <= '0;
            end else begin
                pre_r <= pre_r + W'(1);
            end
        end else begin
            pre_r <= pre_r;
        end
    end
endmodule

// File: rtl/bcd_counter4.sv
// Four-digit BCD up/down counter with prescaler, clear and saturating parallel load.
module bcd_counter4 #(
    parameter int CLK_HZ  = 50_000_000,
    parameter int TICK_HZ = 100,
    parameter int NDIG    = 4
) (
    input  logic           clock,
    input  logic           reset,
    bcd_counter4_if.slave  bus
);
    import counter_pkg::*;

    localparam int DIV = CLK_HZ / TICK_HZ;

    if (NDIG != 4) begin : g_bad_ndig
        $error("bcd_counter4: only NDIG == 4 is supported");
    end

    bcd_vec_t digits_r;
    logic     tick_r;
    logic     wrap_r;
    logic     step_s;
    bcd_vec_t next_s;
    bcd_vec_t load_sat_s;
    bcd_vec_t load_vec_s;
    logic     carry_s;
    logic     dig_carry_s;

    tick_gen #(.DIV(DIV)) u_tick_gen (
        .clock (clock),
        .reset (reset),
        .en    (bus.run),
        .clr   (bus.clear),
        .tick  (step_s)
    );

    assign load_vec_s = bus.load_value;

    // ripple carry/borrow across digits; a digit only moves when everything below it wrapped
    always_comb begin
        next_s      = digits_r;
        carry_s     = 1'b1;
        dig_carry_s = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (carry_s) begin
                next_s[i] = bcd_step(digits_r[i], bus.up, dig_carry_s);
                carry_s   = dig_carry_s;
            end else begin
                next_s[i] = digits_r[i];
            end
        end
    end

    // out-of-range load nibbles clamp to 9 so the register never holds non-BCD
    always_comb begin
        load_sat_s = '0;
        for (int i = 0; i < 4; i++) begin
            load_sat_s[i] = bcd_sat(load_vec_s[i]);
        end
    end

    // count register and pulse outputs: reset > clear > load > step
    always_ff @(posedge clock) begin
        if (reset) begin
            digits_r <= '0;
            tick_r   <= 1'b0;
            wrap_r   <= 1'b0;
        end else if (bus.clear) begin
            digits_r <= '0;
            tick_r   <= 1'b0;
            wrap_r   <= 1'b0;
        end else if (bus.load) begin
            digits_r <= load_sat_s;
            tick_r   <= 1'b0;
            wrap_r   <= 1'b0;
        end else if (step_s) begin
            digits_r <= next_s;
            tick_r   <= 1'b1;
            wrap_r   <= carry_s;
        end else begin
            digits_r <= digits_r;
            tick_r   <= 1'b0;
            wrap_r   <= 1'b0;
        end
    end

    assign bus.digits = digits_r;
    assign bus.tick   = tick_r;
    assign bus.wrap   = wrap_r;
endmodule

// File: tb/tb_bcd_counter4.sv
// Directed plus randomized bench for bcd_counter4 (DIV = 10) against an integer count model.
module tb_bcd_counter4;
    logic clock;
    logic reset;
    int   n_vec;
    int   n_err;
    int   m_cnt;
    int   m_pre;
    logic m_tick;
    logic m_wrap;

    bcd_counter4_if bus ();

    bcd_counter4 #(.CLK_HZ(10), .TICK_HZ(1), .NDIG(4)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        int          t;
        r = 16'h0000;
        t = v;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic int sat_value(input logic [15:0] v);
        int s;
        int mul;
        int n;
        s   = 0;
        mul = 1;
        for (int i = 0; i < 4; i++) begin
            n = int'(v[4*i +: 4]);
            if (n > 9) n = 9;
            s   = s + n * mul;
            mul = mul * 10;
        end
        return s;
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_update();
        logic step;
        if (reset) begin
            m_cnt = 0; m_pre = 0; m_tick = 1'b0; m_wrap = 1'b0;
        end else if (bus.clear) begin
            m_cnt = 0; m_pre = 0; m_tick = 1'b0; m_wrap = 1'b0;
        end else begin
            step = bus.run && (m_pre == 9);
            if (bus.run) m_pre = (m_pre + 1) % 10;
            if (bus.load) begin
                m_cnt = sat_value(bus.load_value); m_tick = 1'b0; m_wrap = 1'b0;
            end else if (step) begin
                m_tick = 1'b1;
                if (bus.up) begin
                    m_wrap = (m_cnt == 9999);
                    m_cnt  = (m_cnt + 1) % 10000;
                end else begin
                    m_wrap = (m_cnt == 0);
                    m_cnt  = (m_cnt + 9999) % 10000;
                end
            end else begin
                m_tick = 1'b0; m_wrap = 1'b0;
            end
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        model_update();
        #1;
        chk("digits", bus.digits, to_bcd(m_cnt));
        chk("tick", {15'd0, bus.tick}, {15'd0, m_tick});
        chk("wrap", {15'd0, bus.wrap}, {15'd0, m_wrap});
    endtask

    task automatic until_tick(input int max_cyc, output int used);
        used = 0;
        for (int i = 0; i < max_cyc; i++) begin
            cyc();
            used++;
            if (bus.tick) break;
        end
        chk("tick_timeout", {15'd0, bus.tick}, 16'h0001);
    endtask

    task automatic load_once(input logic [15:0] v);
        bus.load       = 1'b1;
        bus.load_value = v;
        cyc();
        bus.load = 1'b0;
    endtask

    initial begin
        int used;
        int ticks;
        int r;
        n_vec = 0; n_err = 0;
        m_cnt = 0; m_pre = 0; m_tick = 1'b0; m_wrap = 1'b0;
        reset = 1'b1;
        bus.run = 1'b1; bus.up = 1'b1; bus.clear = 1'b0; bus.load = 1'b0;
        bus.load_value = 16'h0000;
        #1;
        for (int i = 0; i < 3; i++) cyc();
        chk("reset_digits", bus.digits, 16'h0000);
        reset = 1'b0;

        // first step 10 cycles after reset release
        until_tick(20, used);
        chk("first_step_latency", 16'(used), 16'd10);
        chk("first_step_digits", bus.digits, 16'h0001);

        // carry ripple and up wrap
        load_once(16'h0999);
        until_tick(20, used);
        chk("carry_digits", bus.digits, 16'h1000);
        chk("carry_wrap", {15'd0, bus.wrap}, 16'h0000);
        load_once(16'h9999);
        until_tick(20, used);
        chk("upwrap_digits", bus.digits, 16'h0000);
        chk("upwrap_wrap", {15'd0, bus.wrap}, 16'h0001);
        cyc();
        chk("upwrap_pulse_end", {15'd0, bus.wrap}, 16'h0000);

        // borrow ripple and down wrap
        bus.up = 1'b0;
        load_once(16'h1000);
        until_tick(20, used);
        chk("borrow_digits", bus.digits, 16'h0999);
        load_once(16'h0000);
        until_tick(20, used);
        chk("downwrap_digits", bus.digits, 16'h9999);
        chk("downwrap_wrap", {15'd0, bus.wrap}, 16'h0001);

        // pause: 5 run, 7 hold, then step 5 cycles after resume
        bus.up = 1'b1; bus.run = 1'b0; bus.clear = 1'b1;
        cyc();
        bus.clear = 1'b0; bus.run = 1'b1;
        ticks = 0;
        for (int i = 0; i < 5; i++) begin cyc(); if (bus.tick) ticks++; end
        bus.run = 1'b0;
        for (int i = 0; i < 7; i++) begin cyc(); if (bus.tick) ticks++; end
        bus.run = 1'b1;
        until_tick(20, used);
        ticks++;
        chk("pause_resume_latency", 16'(used), 16'd5);
        for (int i = 0; i < 8; i++) begin cyc(); if (bus.tick) ticks++; end
        chk("pause_tick_count", 16'(ticks), 16'd1);

        // clear and load on a step edge
        for (int i = 0; i < 20 && m_pre != 9; i++) cyc();
        bus.clear = 1'b1; bus.load = 1'b1; bus.load_value = 16'h1234;
        cyc();
        chk("prio_clear_digits", bus.digits, 16'h0000);
        chk("prio_clear_tick", {15'd0, bus.tick}, 16'h0000);
        bus.clear = 1'b0; bus.load = 1'b0;
        for (int i = 0; i < 20 && m_pre != 9; i++) cyc();
        load_once(16'h1234);
        chk("prio_load_digits", bus.digits, 16'h1234);
        chk("prio_load_tick", {15'd0, bus.tick}, 16'h0000);
        until_tick(20, used);
        chk("after_load_step_gap", 16'(used), 16'd10);
        load_once(16'hA5F3);
        chk("sat_load_digits", bus.digits, 16'h9593);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            r = int'($urandom_range(0, 99));
            reset     = (r == 99);
            bus.clear = (r < 2);
            bus.load  = (r >= 2 && r < 7);
            bus.run   = ($urandom_range(0, 9) != 0);
            bus.up    = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 5))
                0:       bus.load_value = 16'h9999;
                1:       bus.load_value = 16'h0000;
                2:       bus.load_value = 16'h9998;
                3:       bus.load_value = 16'h0001;
                default: bus.load_value = 16'($urandom);
            endcase
            cyc();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
